// File: rtl/trg_gen.sv
// trg_gen: programmable periodic/burst trigger pulse generator with a bus register file.
// Optional macro TRG_GEN_IRQ_EN adds the burst-done interrupt and the IRQ register at 0x14.
module trg_gen #(
    parameter int CW = 32,
    parameter int WW = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        evi_rst,
    input  logic        evi_str,
    input  logic        evi_stp,
    input  logic        evi_swt,
    output logic        trg,
    output logic        run,
    output logic        irq,
    input  logic        bus_wen,
    input  logic        bus_ren,
    input  logic [7:0]  bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        bus_ack,
    output logic        bus_err
);

    localparam logic [7:0]    A_CTL   = 8'h00;
    localparam logic [7:0]    A_PER   = 8'h04;
    localparam logic [7:0]    A_CNT   = 8'h08;
    localparam logic [7:0]    A_WID   = 8'h0C;
    localparam logic [7:0]    A_STS   = 8'h10;
`ifdef TRG_GEN_IRQ_EN
    localparam logic [7:0]    A_IRQ   = 8'h14;
`endif
    localparam logic [CW-1:0] CW_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CW_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WW-1:0] WW_ZERO = {WW{1'b0}};
    localparam logic [WW-1:0] WW_ONE  = {{(WW-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_ONE  = 2'd2
    } state_t;

    state_t        r_state;
    logic          r_trg;
    logic          r_run;
    logic [CW-1:0] r_per;
    logic [CW-1:0] r_cnt;
    logic [WW-1:0] r_wid;
    logic [CW-1:0] r_sts;
    logic [CW-1:0] r_per_cnt;
    logic [CW-1:0] r_pls_cnt;
    logic [WW-1:0] r_wid_cnt;
    logic [CW-1:0] r_per_s;
    logic [WW-1:0] r_wid_s;
    logic          r_ack;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic          r_irq;
    logic          r_irq_flag;

    logic [31:0]   w_rdat;
    logic          w_err;
    logic          w_wr_ok;
    logic          w_ctl_wr;
    logic          w_cmd_rst;
    logic          w_cmd_str;
    logic          w_cmd_stp;
    logic          w_cmd_swt;
    logic          w_wrap;
    logic [CW-1:0] w_per_inc;
    logic [CW-1:0] w_pls_inc;
    logic [CW-1:0] w_wid_ext;
    logic          w_burst_done;

    // Address decode: read mux and error classification for the current access
    always_comb begin
        w_rdat = 32'h0000_0000;
        w_err  = 1'b0;
        case (bus_addr)
            A_CTL:   w_rdat = {31'b0, r_run};
            A_PER:   w_rdat = 32'(r_per);
            A_CNT:   w_rdat = 32'(r_cnt);
            A_WID:   w_rdat = 32'(r_wid);
            A_STS: begin
                w_rdat = 32'(r_sts);
                w_err  = bus_wen;
            end
`ifdef TRG_GEN_IRQ_EN
            A_IRQ:   w_rdat = {31'b0, r_irq_flag};
`endif
            default: w_err = 1'b1;
        endcase
    end

    assign w_wr_ok   = bus_wen & ~w_err;
    assign w_ctl_wr  = w_wr_ok & (bus_addr == A_CTL);
    assign w_cmd_rst = evi_rst | (w_ctl_wr & bus_wdata[0]);
    assign w_cmd_str = evi_str | (w_ctl_wr & bus_wdata[1]);
    assign w_cmd_stp = evi_stp | (w_ctl_wr & bus_wdata[2]);
    assign w_cmd_swt = evi_swt | (w_ctl_wr & bus_wdata[3]);

    assign w_wrap       = (r_per_cnt == r_per_s);
    assign w_per_inc    = r_per_cnt + CW_ONE;
    assign w_pls_inc    = r_pls_cnt + CW_ONE;
    assign w_wid_ext    = CW'(r_wid_s);
    assign w_burst_done = w_wrap && (r_cnt != CW_ZERO) && (w_pls_inc == r_cnt);

    // Bus response: ack, error and read data one cycle after the strobe
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= 32'h0000_0000;
        end else begin
            r_ack <= bus_wen | bus_ren;
            r_err <= (bus_wen | bus_ren) & w_err;
            if (bus_ren && !bus_wen && !w_err) begin
                r_rdata <= w_rdat;
            end else begin
                r_rdata <= 32'h0000_0000;
            end
        end
    end

    // Configuration registers; the generator only samples them at period boundaries
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_per <= CW_ZERO;
            r_cnt <= CW_ZERO;
            r_wid <= WW_ZERO;
        end else if (w_wr_ok) begin
            case (bus_addr)
                A_PER:   r_per <= bus_wdata[CW-1:0];
                A_CNT:   r_cnt <= bus_wdata[CW-1:0];
                A_WID:   r_wid <= bus_wdata[WW-1:0];
                default: r_per <= r_per;
            endcase
        end else begin
            r_per <= r_per;
        end
    end

`ifdef TRG_GEN_IRQ_EN
    logic w_irq_set;
    assign w_irq_set = (r_state == ST_RUN) & w_burst_done & ~w_cmd_rst & ~w_cmd_stp;

    // Burst-done pulse and sticky pending flag; a new completion wins over a clear
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_irq      <= 1'b0;
            r_irq_flag <= 1'b0;
        end else begin
            r_irq <= w_irq_set;
            if (w_irq_set) begin
                r_irq_flag <= 1'b1;
            end else if (w_wr_ok && (bus_addr == A_IRQ) && bus_wdata[0]) begin
                r_irq_flag <= 1'b0;
            end else begin
                r_irq_flag <= r_irq_flag;
            end
        end
    end
`else
    assign r_irq      = 1'b0;
    assign r_irq_flag = 1'b0;
`endif

    // Generator FSM; commands are prioritised RST > STP > STR > SWT
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= ST_IDLE;
            r_trg     <= 1'b0;
            r_run     <= 1'b0;
            r_per_cnt <= CW_ZERO;
            r_pls_cnt <= CW_ZERO;
            r_wid_cnt <= WW_ZERO;
            r_per_s   <= CW_ZERO;
            r_wid_s   <= WW_ZERO;
            r_sts     <= CW_ZERO;
        end else if (w_cmd_rst) begin
            r_state   <= ST_IDLE;
            r_trg     <= 1'b0;
            r_run     <= 1'b0;
            r_per_cnt <= CW_ZERO;
            r_pls_cnt <= CW_ZERO;
            r_wid_cnt <= WW_ZERO;
            r_sts     <= CW_ZERO;
        end else if (w_cmd_stp) begin
            r_state <= ST_IDLE;
            r_trg   <= 1'b0;
            r_run   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_cmd_str) begin
                        r_state   <= ST_RUN;
                        r_trg     <= 1'b1;
                        r_run     <= 1'b1;
                        r_per_cnt <= CW_ZERO;
                        r_pls_cnt <= CW_ZERO;
                        r_per_s   <= r_per;
                        r_wid_s   <= r_wid;
                    end else if (w_cmd_swt) begin
                        r_state   <= ST_ONE;
                        r_trg     <= 1'b1;
                        r_run     <= 1'b0;
                        r_wid_cnt <= WW_ZERO;
                        r_wid_s   <= r_wid;
                    end else begin
                        r_trg <= 1'b0;
                        r_run <= 1'b0;
                    end
                end
                ST_RUN: begin
                    // trg mirrors (per_cnt <= WID_s) for the value per_cnt takes next cycle
                    if (w_wrap) begin
                        r_sts     <= r_sts + CW_ONE;
                        r_pls_cnt <= w_pls_inc;
                        r_per_cnt <= CW_ZERO;
                        r_per_s   <= r_per;
                        r_wid_s   <= r_wid;
                        if (w_burst_done) begin
                            r_state <= ST_IDLE;
                            r_trg   <= 1'b0;
                            r_run   <= 1'b0;
                        end else begin
                            r_trg <= 1'b1;
                            r_run <= 1'b1;
                        end
                    end else begin
                        r_per_cnt <= w_per_inc;
                        r_trg     <= (w_per_inc <= w_wid_ext);
                        r_run     <= 1'b1;
                    end
                end
                ST_ONE: begin
                    if (r_wid_cnt == r_wid_s) begin
                        r_state <= ST_IDLE;
                        r_trg   <= 1'b0;
                        r_sts   <= r_sts + CW_ONE;
                    end else begin
                        r_wid_cnt <= r_wid_cnt + WW_ONE;
                        r_trg     <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_trg   <= 1'b0;
                    r_run   <= 1'b0;
                end
            endcase
        end
    end

    assign trg       = r_trg;
    assign run       = r_run;
    assign irq       = r_irq;
    assign bus_rdata = r_rdata;
    assign bus_ack   = r_ack;
    assign bus_err   = r_err;

endmodule

// File: tb/tb_trg_gen.sv
// Directed bench for trg_gen: hand-computed trigger patterns, bus accesses and reset behaviour.
module tb_trg_gen;

    logic        clk;
    logic        rstn;
    logic        evi_rst;
    logic        evi_str;
    logic        evi_stp;
    logic        evi_swt;
    logic        trg;
    logic        run;
    logic        irq;
    logic        bus_wen;
    logic        bus_ren;
    logic [7:0]  bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        bus_ack;
    logic        bus_err;

    int checks = 0;
    int errors = 0;

    trg_gen dut (
        .clk       (clk),
        .rstn      (rstn),
        .evi_rst   (evi_rst),
        .evi_str   (evi_str),
        .evi_stp   (evi_stp),
        .evi_swt   (evi_swt),
        .trg       (trg),
        .run       (run),
        .irq       (irq),
        .bus_wen   (bus_wen),
        .bus_ren   (bus_ren),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic [7:0] a, input logic [31:0] d, input logic exp_err);
        bus_wen   = 1'b1;
        bus_addr  = a;
        bus_wdata = d;
        tick();
        bus_wen = 1'b0;
        chk("wr_ack", {31'b0, bus_ack}, 32'd1);
        chk("wr_err", {31'b0, bus_err}, {31'b0, exp_err});
    endtask

    task automatic bus_read(input string tag, input logic [7:0] a, input logic [31:0] exp_d,
                            input logic exp_err);
        bus_ren  = 1'b1;
        bus_addr = a;
        tick();
        bus_ren = 1'b0;
        chk({tag, "_ack"}, {31'b0, bus_ack}, 32'd1);
        chk({tag, "_err"}, {31'b0, bus_err}, {31'b0, exp_err});
        chk({tag, "_data"}, bus_rdata, exp_d);
    endtask

    task automatic pulse_rst();
        evi_rst = 1'b1;
        tick();
        evi_rst = 1'b0;
    endtask

    initial begin
        rstn = 1'b0; evi_rst = 1'b0; evi_str = 1'b0; evi_stp = 1'b0; evi_swt = 1'b0;
        bus_wen = 1'b0; bus_ren = 1'b0; bus_addr = 8'h00; bus_wdata = 32'h0;
        #12;
        chk("rst_trg", {31'b0, trg}, 32'd0);
        chk("rst_run", {31'b0, run}, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_ack", {31'b0, bus_ack}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        bus_read("rst_per", 8'h04, 32'd0, 1'b0);
        bus_read("rst_cnt", 8'h08, 32'd0, 1'b0);
        bus_read("rst_wid", 8'h0C, 32'd0, 1'b0);
        bus_read("rst_sts", 8'h10, 32'd0, 1'b0);

        // Burst of 8 one-cycle pulses every 5 cycles, started from the bus
        bus_write(8'h04, 32'd4, 1'b0);
        bus_write(8'h08, 32'd8, 1'b0);
        bus_write(8'h0C, 32'd0, 1'b0);
        bus_write(8'h00, 32'h2, 1'b0);
        for (int c = 1; c <= 45; c++) begin
            chk("burst_trg", {31'b0, trg}, {31'b0, (c <= 40) && ((c - 1) % 5 == 0)});
            chk("burst_run", {31'b0, run}, {31'b0, c <= 40});
            tick();
        end
        bus_read("burst_sts", 8'h10, 32'd8, 1'b0);

        // Continuous run PER=9 WID=2, stopped by event on cycle 37
        pulse_rst();
        bus_read("clr_sts", 8'h10, 32'd0, 1'b0);
        bus_write(8'h04, 32'd9, 1'b0);
        bus_write(8'h0C, 32'd2, 1'b0);
        bus_write(8'h08, 32'd0, 1'b0);
        evi_str = 1'b1;
        tick();
        evi_str = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            chk("cont_trg", {31'b0, trg}, {31'b0, (c <= 37) && ((c - 1) % 10 < 3)});
            chk("cont_run", {31'b0, run}, {31'b0, c <= 37});
            if (c == 37) evi_stp = 1'b1;
            tick();
            evi_stp = 1'b0;
        end
        bus_read("cont_sts", 8'h10, 32'd3, 1'b0);

        // Software one-shot of WID+1 = 6 cycles
        pulse_rst();
        bus_write(8'h0C, 32'd5, 1'b0);
        evi_swt = 1'b1;
        tick();
        evi_swt = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            chk("one_trg", {31'b0, trg}, {31'b0, c <= 6});
            chk("one_run", {31'b0, run}, 32'd0);
            tick();
        end
        bus_read("one_sts", 8'h10, 32'd1, 1'b0);

        // SWT while running leaves the pattern untouched; bus STP ends the run
        bus_write(8'h0C, 32'd2, 1'b0);
        evi_str = 1'b1;
        tick();
        evi_str = 1'b0;
        for (int c = 1; c <= 25; c++) begin
            chk("swt_run_trg", {31'b0, trg}, {31'b0, (c - 1) % 10 < 3});
            if (c == 4) evi_swt = 1'b1;
            tick();
            evi_swt = 1'b0;
        end
        bus_write(8'h00, 32'h4, 1'b0);
        chk("stp_trg", {31'b0, trg}, 32'd0);
        chk("stp_run", {31'b0, run}, 32'd0);
        bus_read("stp_sts", 8'h10, 32'd3, 1'b0);

        // Coinciding commands: STP beats STR, RST beats STR
        evi_str = 1'b1;
        bus_write(8'h00, 32'h4, 1'b0);
        evi_str = 1'b0;
        chk("strstp_run", {31'b0, run}, 32'd0);
        chk("strstp_trg", {31'b0, trg}, 32'd0);
        tick();
        chk("strstp_run2", {31'b0, run}, 32'd0);
        evi_rst = 1'b1;
        evi_str = 1'b1;
        tick();
        evi_rst = 1'b0;
        evi_str = 1'b0;
        chk("rststr_run", {31'b0, run}, 32'd0);
        chk("rststr_trg", {31'b0, trg}, 32'd0);
        tick();
        chk("rststr_run2", {31'b0, run}, 32'd0);
        bus_read("rststr_sts", 8'h10, 32'd0, 1'b0);

        // PER rewritten mid-period: current period stays 10, later ones are 3
        bus_write(8'h04, 32'd9, 1'b0);
        bus_write(8'h0C, 32'd0, 1'b0);
        evi_str = 1'b1;
        tick();
        evi_str = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            chk("reper_trg", {31'b0, trg}, {31'b0, (c == 1) || ((c >= 11) && ((c - 11) % 3 == 0))});
            if (c == 5) chk("reper_ack", {31'b0, bus_ack}, 32'd1);
            if (c == 4) begin
                bus_wen   = 1'b1;
                bus_addr  = 8'h04;
                bus_wdata = 32'd2;
            end
            tick();
            bus_wen = 1'b0;
        end
        evi_stp = 1'b1;
        tick();
        evi_stp = 1'b0;
        chk("reper_stop", {31'b0, run}, 32'd0);

        // PER=0 WID=0: every cycle is a pulse, burst of 3
        pulse_rst();
        bus_write(8'h04, 32'd0, 1'b0);
        bus_write(8'h08, 32'd3, 1'b0);
        bus_write(8'h00, 32'h2, 1'b0);
        for (int c = 1; c <= 5; c++) begin
            chk("p0_trg", {31'b0, trg}, {31'b0, c <= 3});
            chk("p0_run", {31'b0, run}, {31'b0, c <= 3});
            tick();
        end
        bus_read("p0_sts", 8'h10, 32'd3, 1'b0);

        // Bus error cases
        bus_read("unmapped_rd", 8'h20, 32'd0, 1'b1);
        bus_write(8'h20, 32'd1, 1'b1);
        bus_write(8'h10, 32'd7, 1'b1);
        bus_read("sts_kept", 8'h10, 32'd3, 1'b0);
        bus_read("ctl_rd", 8'h00, 32'd0, 1'b0);

        // Burst of 2 with PER=1: completion produces irq when the feature is built in
        pulse_rst();
        bus_write(8'h04, 32'd1, 1'b0);
        bus_write(8'h08, 32'd2, 1'b0);
        bus_read("per_rd", 8'h04, 32'd1, 1'b0);
        bus_read("cnt_rd", 8'h08, 32'd2, 1'b0);
        evi_str = 1'b1;
        tick();
        evi_str = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            chk("irq_trg", {31'b0, trg}, {31'b0, (c == 1) || (c == 3)});
`ifdef TRG_GEN_IRQ_EN
            chk("irq_pulse", {31'b0, irq}, {31'b0, c == 5});
`else
            chk("irq_tied", {31'b0, irq}, 32'd0);
`endif
            tick();
        end
`ifdef TRG_GEN_IRQ_EN
        bus_read("irq_set", 8'h14, 32'd1, 1'b0);
        bus_write(8'h14, 32'd1, 1'b0);
        bus_read("irq_clr", 8'h14, 32'd0, 1'b0);
`else
        bus_read("irq_unmapped", 8'h14, 32'd0, 1'b1);
`endif

        // Asynchronous reset drops trg between clock edges
        bus_write(8'h04, 32'd9, 1'b0);
        bus_write(8'h0C, 32'd5, 1'b0);
        bus_write(8'h08, 32'd0, 1'b0);
        bus_write(8'h00, 32'h2, 1'b0);
        tick();
        chk("arst_pre_trg", {31'b0, trg}, 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("arst_trg", {31'b0, trg}, 32'd0);
        chk("arst_run", {31'b0, run}, 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        tick();
        bus_read("arst_per", 8'h04, 32'd0, 1'b0);
        bus_read("arst_wid", 8'h0C, 32'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
